// File: rtl/sram_port_arbiter.sv
// Arbiter sharing one single-port synchronous SRAM between instruction-fetch and data requesters.
// Data has priority; a starvation counter forces an instruction grant after STARVE_MAX data grants.
module sram_port_arbiter #(
    parameter int unsigned ADDR_W     = 32,
    parameter int unsigned DATA_W     = 32,
    parameter int unsigned STARVE_MAX = 4
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic                  i_req,
    input  logic [ADDR_W-1:0]     i_addr,
    output logic                  i_addr_ok,
    output logic                  i_data_ok,
    output logic [DATA_W-1:0]     i_rdata,
    input  logic                  d_req,
    input  logic                  d_wr,
    input  logic [DATA_W/8-1:0]   d_wstrb,
    input  logic [ADDR_W-1:0]     d_addr,
    input  logic [DATA_W-1:0]     d_wdata,
    output logic                  d_addr_ok,
    output logic                  d_data_ok,
    output logic [DATA_W-1:0]     d_rdata,
    output logic                  sram_en,
    output logic [DATA_W/8-1:0]   sram_we,
    output logic [ADDR_W-1:0]     sram_addr,
    output logic [DATA_W-1:0]     sram_wdata,
    input  logic [DATA_W-1:0]     sram_rdata,
    output logic                  busy
);

    localparam int unsigned StrbW = DATA_W / 8;
    localparam int unsigned CntW  = (STARVE_MAX > 0) ? $clog2(STARVE_MAX + 1) : 1;
    localparam logic [CntW-1:0] StarveMaxC = CntW'(STARVE_MAX);

    typedef enum logic [1:0] {
        OwnNone = 2'd0,
        OwnInst = 2'd1,
        OwnData = 2'd2
    } owner_e;

    owner_e          owner_q, owner_d;
    logic [CntW-1:0] starve_q, starve_d;
    logic            force_inst, gnt_data, gnt_inst;

    always_comb begin
        force_inst = i_req && (starve_q == StarveMaxC);
        gnt_data   = d_req && !force_inst;
        gnt_inst   = i_req && !gnt_data;
    end

    always_comb begin
        owner_d  = OwnNone;
        starve_d = starve_q;
        if (gnt_data) begin
            owner_d = OwnData;
        end else if (gnt_inst) begin
            owner_d = OwnInst;
        end
        if (gnt_inst || !i_req) begin
            starve_d = '0;
        end else if (gnt_data && (starve_q != StarveMaxC)) begin
            starve_d = starve_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            owner_q  <= OwnNone;
            starve_q <= '0;
        end else begin
            owner_q  <= owner_d;
            starve_q <= starve_d;
        end
    end

    // Grant-side outputs are combinational, so they are gated while reset is held.
    always_comb begin
        i_addr_ok  = 1'b0;
        d_addr_ok  = 1'b0;
        sram_en    = 1'b0;
        sram_we    = '0;
        sram_addr  = '0;
        sram_wdata = '0;
        if (resetn) begin
            if (gnt_data) begin
                d_addr_ok  = 1'b1;
                sram_en    = 1'b1;
                sram_addr  = d_addr;
                sram_wdata = d_wdata;
                sram_we    = d_wr ? d_wstrb : {StrbW{1'b0}};
            end else if (gnt_inst) begin
                i_addr_ok = 1'b1;
                sram_en   = 1'b1;
                sram_addr = i_addr;
            end
        end
    end

    always_comb begin
        i_data_ok = (owner_q == OwnInst);
        d_data_ok = (owner_q == OwnData);
        busy      = (owner_q != OwnNone);
        i_rdata   = i_data_ok ? sram_rdata : '0;
        d_rdata   = d_data_ok ? sram_rdata : '0;
    end

endmodule

// File: tb/tb_sram_port_arbiter.sv
// Directed bench for sram_port_arbiter with a behavioural SRAM and a response scoreboard queue.
module tb_sram_port_arbiter;

    logic        clk = 1'b0;
    logic        resetn;
    logic        i_req, i_addr_ok, i_data_ok;
    logic [31:0] i_addr, i_rdata;
    logic        d_req, d_wr, d_addr_ok, d_data_ok;
    logic [3:0]  d_wstrb;
    logic [31:0] d_addr, d_wdata, d_rdata;
    logic        sram_en, busy;
    logic [3:0]  sram_we;
    logic [31:0] sram_addr, sram_wdata;
    logic [31:0] sram_rdata;

    int tests  = 0;
    int failed = 0;

    typedef struct packed {
        logic        valid;
        logic        is_d;
        logic        chk;
        logic [31:0] data;
    } resp_t;

    resp_t exp_q[$];

    logic [31:0] mem [0:1023];
    logic        preload;

    always #5 clk = ~clk;

    sram_port_arbiter #(
        .ADDR_W    (32),
        .DATA_W    (32),
        .STARVE_MAX(4)
    ) dut (
        .clk       (clk),
        .resetn    (resetn),
        .i_req     (i_req),
        .i_addr    (i_addr),
        .i_addr_ok (i_addr_ok),
        .i_data_ok (i_data_ok),
        .i_rdata   (i_rdata),
        .d_req     (d_req),
        .d_wr      (d_wr),
        .d_wstrb   (d_wstrb),
        .d_addr    (d_addr),
        .d_wdata   (d_wdata),
        .d_addr_ok (d_addr_ok),
        .d_data_ok (d_data_ok),
        .d_rdata   (d_rdata),
        .sram_en   (sram_en),
        .sram_we   (sram_we),
        .sram_addr (sram_addr),
        .sram_wdata(sram_wdata),
        .sram_rdata(sram_rdata),
        .busy      (busy)
    );

    // Read-first SRAM macro with byte enables, word-indexed by addr[11:2].
    always @(posedge clk) begin
        if (preload) begin
            mem[0]   <= 32'h02800c0c;
            mem[64]  <= 32'h00000000;
            mem[128] <= 32'h11223344;
        end else if (sram_en) begin
            sram_rdata <= mem[sram_addr[11:2]];
            for (int b = 0; b < 4; b++) begin
                if (sram_we[b]) mem[sram_addr[11:2]][8*b +: 8] <= sram_wdata[8*b +: 8];
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One clock: check grants and SRAM drive, retire last cycle's response, queue this one.
    task automatic cyc(input logic gi, input logic gd, input logic dchk, input logic [31:0] rdat);
        resp_t e;
        resp_t n;
        @(negedge clk);
        chk("i_addr_ok", {31'd0, i_addr_ok}, {31'd0, gi});
        chk("d_addr_ok", {31'd0, d_addr_ok}, {31'd0, gd});
        if (gd) begin
            chk("sram_en_d", {31'd0, sram_en}, 32'd1);
            chk("sram_addr_d", sram_addr, d_addr);
            chk("sram_we_d", {28'd0, sram_we}, d_wr ? {28'd0, d_wstrb} : 32'd0);
            chk("sram_wdata_d", sram_wdata, d_wdata);
        end else if (gi) begin
            chk("sram_en_i", {31'd0, sram_en}, 32'd1);
            chk("sram_addr_i", sram_addr, i_addr);
            chk("sram_we_i", {28'd0, sram_we}, 32'd0);
            chk("sram_wdata_i", sram_wdata, 32'd0);
        end else begin
            chk("sram_idle", {sram_en, sram_we, 27'd0} | sram_addr | sram_wdata, 32'd0);
        end
        e = (exp_q.size() > 0) ? exp_q.pop_front() : '0;
        chk("i_data_ok", {31'd0, i_data_ok}, {31'd0, e.valid & ~e.is_d});
        chk("d_data_ok", {31'd0, d_data_ok}, {31'd0, e.valid & e.is_d});
        chk("both_data_ok", {31'd0, i_data_ok & d_data_ok}, 32'd0);
        chk("busy", {31'd0, busy}, {31'd0, e.valid});
        if (!e.valid || e.is_d) chk("i_rdata_zero", i_rdata, 32'd0);
        if (!e.valid || !e.is_d) chk("d_rdata_zero", d_rdata, 32'd0);
        if (e.valid && e.chk) chk(e.is_d ? "d_rdata" : "i_rdata", e.is_d ? d_rdata : i_rdata, e.data);
        n.valid = gi | gd;
        n.is_d  = gd;
        n.chk   = dchk;
        n.data  = rdat;
        exp_q.push_back(n);
        @(posedge clk);
        #1;
    endtask

    task automatic rst_chk();
        @(negedge clk);
        chk("rst_addr_ok", {30'd0, i_addr_ok, d_addr_ok}, 32'd0);
        chk("rst_data_ok", {29'd0, i_data_ok, d_data_ok, busy}, 32'd0);
        chk("rst_sram_ctl", {27'd0, sram_en, sram_we}, 32'd0);
        chk("rst_sram_addr", sram_addr, 32'd0);
        chk("rst_sram_wdata", sram_wdata, 32'd0);
        chk("rst_rdata", i_rdata | d_rdata, 32'd0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        resetn  = 1'b0;
        preload = 1'b1;
        i_req   = 1'b1;
        d_req   = 1'b1;
        d_wr    = 1'b1;
        d_wstrb = 4'hF;
        i_addr  = 32'h1c000000;
        d_addr  = 32'h00000100;
        d_wdata = 32'h12345678;
        @(posedge clk);
        #1;
        rst_chk();
        preload = 1'b0;
        rst_chk();

        // Instruction fetch after reset.
        resetn = 1'b1;
        d_req  = 1'b0;
        d_wr   = 1'b0;
        cyc(1'b1, 1'b0, 1'b1, 32'h02800c0c);
        i_req = 1'b0;
        cyc(1'b0, 1'b0, 1'b0, 32'h0);

        // Full-word write then read-back.
        d_req   = 1'b1;
        d_wr    = 1'b1;
        d_addr  = 32'h00000100;
        d_wstrb = 4'hF;
        d_wdata = 32'hDEADBEEF;
        cyc(1'b0, 1'b1, 1'b0, 32'h0);
        d_wr    = 1'b0;
        d_wstrb = 4'h0;
        cyc(1'b0, 1'b1, 1'b1, 32'hDEADBEEF);
        d_req = 1'b0;
        cyc(1'b0, 1'b0, 1'b0, 32'h0);

        // Both requesters held: D,D,D,D,I repeating.
        i_req = 1'b1;
        d_req = 1'b1;
        for (int k = 0; k < 12; k++) begin
            if (k % 5 == 4) cyc(1'b1, 1'b0, 1'b1, 32'h02800c0c);
            else            cyc(1'b0, 1'b1, 1'b1, 32'hDEADBEEF);
        end
        i_req = 1'b0;
        d_req = 1'b0;
        cyc(1'b0, 1'b0, 1'b0, 32'h0);

        // Back-to-back I then D grants.
        i_req = 1'b1;
        cyc(1'b1, 1'b0, 1'b1, 32'h02800c0c);
        i_req = 1'b0;
        d_req = 1'b1;
        cyc(1'b0, 1'b1, 1'b1, 32'hDEADBEEF);
        d_req = 1'b0;
        cyc(1'b0, 1'b0, 1'b0, 32'h0);
        cyc(1'b0, 1'b0, 1'b0, 32'h0);

        // Partial byte-strobe write.
        d_req   = 1'b1;
        d_wr    = 1'b1;
        d_addr  = 32'h00000200;
        d_wstrb = 4'h3;
        d_wdata = 32'hAAAABBBB;
        cyc(1'b0, 1'b1, 1'b0, 32'h0);
        d_wr    = 1'b0;
        d_wstrb = 4'h0;
        cyc(1'b0, 1'b1, 1'b1, 32'h1122BBBB);
        d_req = 1'b0;
        cyc(1'b0, 1'b0, 1'b0, 32'h0);

        // Reset the cycle after a data grant: its response must be dropped.
        d_req = 1'b1;
        cyc(1'b0, 1'b1, 1'b1, 32'h1122BBBB);
        resetn = 1'b0;
        exp_q.delete();
        i_req = 1'b1;
        rst_chk();
        rst_chk();
        resetn = 1'b1;
        d_req  = 1'b0;
        cyc(1'b1, 1'b0, 1'b1, 32'h02800c0c);
        i_req = 1'b0;
        cyc(1'b0, 1'b0, 1'b0, 32'h0);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule

// File: doc/sram_port_arbiter.md
Name: sram_port_arbiter

Overview:
- Shares one synchronous single-port SRAM between the CPU's instruction-fetch requester and data-access requester.
- Both requesters use a req / addr_ok / data_ok handshake.
- Sits between the CPU core's instruction and data SRAM interfaces and a unified SRAM macro.
- Data accesses have priority. A starvation counter forces an instruction grant after a bounded number of consecutive data grants.

Parameters:
- ADDR_W, 32, address width of both requesters and the SRAM.
- DATA_W, 32, data width. Byte-strobe width is DATA_W/8.
- STARVE_MAX, 4, maximum consecutive data grants while i_req is pending. After that, the instruction side is granted.

Ports:
- clk  input  1  system clock; all state updates on its rising edge.
- resetn  input  1  reset, asynchronous, active-low.
- i_req  input  1  instruction read request.
- i_addr  input  ADDR_W  instruction address.
- i_addr_ok  output  1  instruction request accepted this cycle.
- i_data_ok  output  1  instruction read data valid this cycle.
- i_rdata  output  DATA_W  instruction read data.
- d_req  input  1  data request.
- d_wr  input  1  1 = write, 0 = read.
- d_wstrb  input  DATA_W/8  byte write strobes; ignored for reads.
- d_addr  input  ADDR_W  data address.
- d_wdata  input  DATA_W  write data.
- d_addr_ok  output  1  data request accepted this cycle.
- d_data_ok  output  1  data read or write complete this cycle.
- d_rdata  output  DATA_W  data read data.
- sram_en  output  1  SRAM enable.
- sram_we  output  DATA_W/8  SRAM byte write enables.
- sram_addr  output  ADDR_W  SRAM address.
- sram_wdata  output  DATA_W  SRAM write data.
- sram_rdata  input  DATA_W  SRAM read data, valid one cycle after the enabling edge.
- busy  output  1  a response is outstanding.

Behaviour:
- Registered state:
  - owner ∈ {NONE, INST, DATA}: which requester's response is due in the current cycle.
  - starve_cnt: width clog2(STARVE_MAX+1).
- Reset (resetn low, asynchronous): owner=NONE, starve_cnt=0.
  - While resetn is low, all combinational outputs are forced to 0: addr_ok ×2, sram_en, sram_we, sram_addr, sram_wdata.
  - data_ok ×2 = 0, busy = 0, rdata ×2 = 0.
- Grant decision, combinational each cycle:
  - force_i = i_req & (starve_cnt == STARVE_MAX).
  - grant_d = d_req & ~force_i.
  - grant_i = i_req & ~grant_d.
  - At most one grant per cycle.
- SRAM drive:
  - On grant_d: sram_en=1, sram_addr=d_addr, sram_wdata=d_wdata, sram_we = d_wr ? d_wstrb : 0.
  - On grant_i: sram_en=1, sram_addr=i_addr, sram_we=0, sram_wdata=0.
  - With no grant, all SRAM outputs are 0.
- addr_ok: i_addr_ok = grant_i and d_addr_ok = grant_d, in the same cycle (combinational).
- Next owner: DATA if grant_d, INST if grant_i, else NONE.
  - A new request can be issued in the same cycle a previous response returns. Throughput is 1 access/cycle.
- Response timing: data_ok is asserted exactly one cycle after the corresponding addr_ok.
  - i_data_ok = (owner==INST); d_data_ok = (owner==DATA).
  - i_rdata = sram_rdata when owner==INST, else 0. d_rdata follows the same rule for DATA.
  - A write also returns d_data_ok; d_rdata then carries sram_rdata and is don't-care to the requester.
- busy = (owner != NONE).
- starve_cnt update:
  - grant_i or ~i_req → 0.
  - grant_d & i_req → +1, saturating at STARVE_MAX.
  - Otherwise it holds.
- Requester rule: req, addr, wr, wstrb and wdata stay stable from req assertion until addr_ok. The arbiter does not latch un-granted requests.
- Simultaneous i_req & d_req with starve_cnt < STARVE_MAX → data wins. At starve_cnt == STARVE_MAX → instruction wins, and the counter clears on that grant.
- Reset asserted mid-access: the outstanding response is discarded and no data_ok is issued after reset. After resetn rises, the first grant can occur on the next clock cycle.
- Address and data widths pass through unmodified. No address decoding or alignment checks.

Test Plan:
- Reset, then i_req=1 with i_addr=0x1c000000 and SRAM preloaded with 0x02800c0c there → i_addr_ok in cycle 0; i_data_ok=1 with i_rdata=0x02800c0c in cycle 1; d_* outputs stay 0.
- d_req=1, d_wr=1, d_addr=0x100, d_wstrb=0xF, d_wdata=0xDEADBEEF, then a read of 0x100 → write gets d_data_ok the next cycle; read returns 0xDEADBEEF; sram_we=0xF only in the write cycle.
- i_req and d_req held high continuously, STARVE_MAX=4 → grant sequence D,D,D,D,I,D,D,D,D,I,… Each I grant returns i_data_ok exactly one cycle later.
- Back-to-back: I grant in cycle n and D grant in cycle n+1 → i_data_ok in n+1 and d_data_ok in n+2. busy is high in n+1 and n+2. No cycle has both data_ok high.
- d_req with d_wr=1, d_wstrb=0x3 to 0x200 (old 0x11223344), d_wdata=0xAAAABBBB → read-back gives 0x1122BBBB.
- Assert resetn low in the cycle after d_addr_ok → d_data_ok never asserts and all outputs are 0 while reset is low. After release, i_req is granted on the next cycle with owner starting from NONE.
